// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder with programmable wait states and preload port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit       NO_WAIT    = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_START = 4'(WAIT_STATES - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          do_access;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [DW-1:0] acc_wdata;
    logic          acc_in_range;
    logic          ld_in_range;

    function automatic logic in_range(input logic [AW-1:0] a);
        logic [31:0] a_ext;
        a_ext = {{(32-AW){1'b0}}, a};
        return a_ext < 32'(DEPTH);
    endfunction

    // With no wait states the access happens on the accept edge, so it must
    // use the live request fields rather than the latches being loaded.
    assign accept       = (state == IDLE) && !ld_en && req;
    assign do_access    = (accept && NO_WAIT) || ((state == WAIT) && (cnt == 4'd0));
    assign acc_addr     = (state == IDLE) ? addr  : addr_q;
    assign acc_we       = (state == IDLE) ? we    : we_q;
    assign acc_wdata    = (state == IDLE) ? wdata : wdata_q;
    assign acc_in_range = in_range(acc_addr);
    assign ld_in_range  = in_range(ld_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ld_en) begin
                        if (ld_in_range) begin
                            mem[ld_addr] <= ld_data;
                        end
                    end else if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_START;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_access) begin
                ack <= 1'b1;
                if (acc_in_range) begin
                    err <= 1'b0;
                    if (acc_we) begin
                        mem[acc_addr] <= acc_wdata;
                    end else begin
                        rdata <= mem[acc_addr];
                    end
                end else begin
                    err   <= 1'b1;
                    rdata <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder across four parameter configurations.
`default_nettype none

module tb_mem_responder;

    logic       clk;
    logic       rst_n;
    logic       req   [4];
    logic       ld_en [4];
    logic       ack   [4];
    logic       err   [4];
    logic       busy  [4];
    logic [7:0] rdata [4];
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;

    int checks = 0;
    int errors = 0;

    // 0: WS=1 DEPTH=16, 1: WS=0, 2: DEPTH=12 WS=1, 3: WS=3
    mem_responder #(.AW(4), .DW(8), .DEPTH(16), .WAIT_STATES(1)) u_a (
        .clk(clk), .reset(rst_n), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr), .ld_data(ld_data));

    mem_responder #(.AW(4), .DW(8), .DEPTH(16), .WAIT_STATES(0)) u_b (
        .clk(clk), .reset(rst_n), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr), .ld_data(ld_data));

    mem_responder #(.AW(4), .DW(8), .DEPTH(12), .WAIT_STATES(1)) u_c (
        .clk(clk), .reset(rst_n), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2]),
        .ld_en(ld_en[2]), .ld_addr(ld_addr), .ld_data(ld_data));

    mem_responder #(.AW(4), .DW(8), .DEPTH(16), .WAIT_STATES(3)) u_d (
        .clk(clk), .reset(rst_n), .req(req[3]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[3]), .rdata(rdata[3]), .err(err[3]), .busy(busy[3]),
        .ld_en(ld_en[3]), .ld_addr(ld_addr), .ld_data(ld_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int k, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en[k] = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_en[k] = 1'b0;
    endtask

    // Counts edges until ack is seen; start is the number of edges already taken.
    task automatic wait_ack(input int k, input int start, output int lat);
        lat = start;
        while (ack[k] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_txn(input int k, input logic w, input logic [3:0] a, input logic [7:0] d,
                          input int exp_lat, input logic [7:0] exp_rdata, input logic exp_err,
                          input string tag);
        int lat;
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b1;
        we     = w;
        addr   = a;
        wdata  = d;
        wait_ack(k, 0, lat);
        req[k] = 1'b0;
        check({tag, "_lat"},   lat,      exp_lat);
        check({tag, "_rdata"}, rdata[k], exp_rdata);
        check({tag, "_err"},   err[k],   exp_err);
        check({tag, "_busy"},  busy[k],  1'b1);
    endtask

    initial begin
        int lat;
        rst_n   = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        ld_addr = '0;
        ld_data = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]   = 1'b0;
            ld_en[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_ack",   ack[0],   1'b0);
        check("rst_busy",  busy[0],  1'b0);
        check("rst_err",   err[0],   1'b0);
        check("rst_rdata", rdata[0], 8'h00);
        rst_n = 1'b1;

        // Preload and read, one wait state
        preload(0, 4'd1, 8'h86);
        preload(0, 4'd2, 8'h45);
        do_txn(0, 1'b0, 4'd1, 8'h00, 2, 8'h86, 1'b0, "a_rd1");

        // Preload wins over a simultaneous request; request taken next cycle
        @(posedge clk);
        @(negedge clk);
        ld_en[0] = 1'b1; ld_addr = 4'd3; ld_data = 8'h33;
        req[0]   = 1'b1; we = 1'b0; addr = 4'd3;
        @(posedge clk);
        #1;
        check("prio_not_accepted", busy[0], 1'b0);
        @(negedge clk);
        ld_en[0] = 1'b0;
        wait_ack(0, 0, lat);
        req[0] = 1'b0;
        check("prio_lat",   lat,      2);
        check("prio_rdata", rdata[0], 8'h33);

        // Preload during WAIT is ignored
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b1; we = 1'b0; addr = 4'd2;
        @(posedge clk);
        #1;
        check("ldwait_busy", busy[0], 1'b1);
        ld_en[0] = 1'b1; ld_addr = 4'd2; ld_data = 8'hEE;
        wait_ack(0, 1, lat);
        ld_en[0] = 1'b0;
        req[0]   = 1'b0;
        check("ldwait_lat",   lat,      2);
        check("ldwait_rdata", rdata[0], 8'h45);
        do_txn(0, 1'b0, 4'd2, 8'h00, 2, 8'h45, 1'b0, "a_rd2_again");

        // Zero wait states: write then read back
        do_txn(1, 1'b1, 4'd14, 8'h5A, 1, 8'h00, 1'b0, "b_wr14");
        do_txn(1, 1'b0, 4'd14, 8'h00, 1, 8'h5A, 1'b0, "b_rd14");

        // Out of range with DEPTH=12
        preload(2, 4'd11, 8'h77);
        preload(2, 4'd13, 8'h12);
        do_txn(2, 1'b1, 4'd13, 8'hFF, 2, 8'h00, 1'b1, "c_wr13");
        do_txn(2, 1'b0, 4'd11, 8'h00, 2, 8'h77, 1'b0, "c_rd11");
        do_txn(2, 1'b0, 4'd13, 8'h00, 2, 8'h00, 1'b1, "c_rd13");
        do_txn(2, 1'b0, 4'd11, 8'h00, 2, 8'h77, 1'b0, "c_rd11_again");
        @(posedge clk);
        #1;
        check("c_ack_drop", ack[2], 1'b0);
        check("c_err_drop", err[2], 1'b0);

        // Committed transaction with three wait states
        preload(3, 4'd2, 8'h45);
        preload(3, 4'd5, 8'h99);
        @(posedge clk);
        @(negedge clk);
        req[3] = 1'b1; we = 1'b0; addr = 4'd2;
        @(posedge clk);
        #1;
        req[3] = 1'b0;
        addr   = 4'd5;
        we     = 1'b1;
        check("d_busy", busy[3], 1'b1);
        wait_ack(3, 1, lat);
        check("d_lat",   lat,      4);
        check("d_rdata", rdata[3], 8'h45);

        // Reset during WAIT abandons the transaction and clears memory
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b1; we = 1'b0; addr = 4'd1;
        @(posedge clk);
        #1;
        check("rstmid_busy_before", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        req[0] = 1'b0;
        check("rstmid_ack",   ack[0],   1'b0);
        check("rstmid_busy",  busy[0],  1'b0);
        check("rstmid_rdata", rdata[0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 4'd1, 8'h00, 2, 8'h00, 1'b0, "rst_rd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
